// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: register-file default geometry, index/data
// typedefs and the register-index validity helper.
package cpu_pkg;

    localparam int DEF_N_REGS    = 8;
    localparam int DEF_REG_WIDTH = 8;

    typedef logic [$clog2(DEF_N_REGS)-1:0] reg_idx_t;
    typedef logic [DEF_REG_WIDTH-1:0]      reg_data_t;

    // An index is usable when it names a real register and is not the hardwired zero
    function automatic logic idx_valid(input int idx, input int n_regs, input int zero_reg);
        return (idx < n_regs) && !((zero_reg != 0) && (idx == 0));
    endfunction

endpackage

// File: rtl/regfile_2r1w_if.sv
// Register-file bus: writeback write/release, decode reserve, two read ports.
interface regfile_2r1w_if
    import cpu_pkg::*;
#(
    parameter int N_REGS    = DEF_N_REGS,
    parameter int REG_WIDTH = DEF_REG_WIDTH
);
    localparam int ADDR_WIDTH = $clog2(N_REGS);

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [REG_WIDTH-1:0]  wr_data;
    logic                  rd_en_a;
    logic [ADDR_WIDTH-1:0] rd_idx_a;
    logic [REG_WIDTH-1:0]  rd_data_a;
    logic                  rd_busy_a;
    logic                  rd_en_b;
    logic [ADDR_WIDTH-1:0] rd_idx_b;
    logic [REG_WIDTH-1:0]  rd_data_b;
    logic                  rd_busy_b;
    logic                  rsv_en;
    logic [ADDR_WIDTH-1:0] rsv_idx;
    logic                  rsv_stall;

    modport master (
        output wr_en, wr_idx, wr_data,
        output rd_en_a, rd_idx_a, rd_en_b, rd_idx_b,
        output rsv_en, rsv_idx,
        input  rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, rsv_stall
    );

    modport slave (
        input  wr_en, wr_idx, wr_data,
        input  rd_en_a, rd_idx_a, rd_en_b, rd_idx_b,
        input  rsv_en, rsv_idx,
        output rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, rsv_stall
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy flags: set by reserve, cleared by writeback, two lookups.
// Lookups return the post-release value; a same-cycle reserve is not visible.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int N_REGS     = DEF_N_REGS,
    parameter int ADDR_WIDTH = $clog2(N_REGS),
    parameter int ZERO_REG   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_idx,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_idx,
    input  logic [ADDR_WIDTH-1:0] look_idx_a,
    input  logic [ADDR_WIDTH-1:0] look_idx_b,
    output logic                  look_busy_a,
    output logic                  look_busy_b,
    output logic                  set_stall
);

    logic [N_REGS-1:0] busy_q, busy_d;
    logic              clr_ok, set_ok;

    always_comb begin
        clr_ok = clr_en && idx_valid(int'(clr_idx), N_REGS, ZERO_REG);
        set_ok = set_en && idx_valid(int'(set_idx), N_REGS, ZERO_REG);

        // Set is applied after clear so a same-cycle reserve wins
        busy_d = busy_q;
        if (clr_ok) busy_d[clr_idx] = 1'b0;
        if (set_ok) busy_d[set_idx] = 1'b1;

        set_stall = set_ok && busy_q[set_idx];

        look_busy_a = 1'b0;
        if (idx_valid(int'(look_idx_a), N_REGS, ZERO_REG))
            look_busy_a = busy_q[look_idx_a] && !(clr_ok && (clr_idx == look_idx_a));

        look_busy_b = 1'b0;
        if (idx_valid(int'(look_idx_b), N_REGS, ZERO_REG))
            look_busy_b = busy_q[look_idx_b] && !(clr_ok && (clr_idx == look_idx_b));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with busy scoreboard for RAW detection.
// REGFILE_BYPASS_EN: defined = write-first forwarding on reads, undefined = read-first.
module regfile_2r1w
    import cpu_pkg::*;
#(
    parameter int N_REGS    = DEF_N_REGS,
    parameter int REG_WIDTH = DEF_REG_WIDTH,
    parameter int ZERO_REG  = 0
) (
    input  logic          clk,
    input  logic          reset,
    regfile_2r1w_if.slave bus
);

    localparam int ADDR_WIDTH = $clog2(N_REGS);

    logic [REG_WIDTH-1:0] regs_q [N_REGS];
    logic [REG_WIDTH-1:0] regs_d [N_REGS];
    logic [REG_WIDTH-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
    logic                 rd_busy_a_q, rd_busy_a_d, rd_busy_b_q, rd_busy_b_d;
    logic                 look_busy_a, look_busy_b;
    logic                 wr_ok;

    reg_scoreboard #(
        .N_REGS    (N_REGS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .ZERO_REG  (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (reset),
        .clr_en     (bus.wr_en),
        .clr_idx    (bus.wr_idx),
        .set_en     (bus.rsv_en),
        .set_idx    (bus.rsv_idx),
        .look_idx_a (bus.rd_idx_a),
        .look_idx_b (bus.rd_idx_b),
        .look_busy_a(look_busy_a),
        .look_busy_b(look_busy_b),
        .set_stall  (bus.rsv_stall)
    );

    always_comb begin
        wr_ok = bus.wr_en && idx_valid(int'(bus.wr_idx), N_REGS, ZERO_REG);

        regs_d = regs_q;
        if (wr_ok) regs_d[bus.wr_idx] = bus.wr_data;

        rd_data_a_d = rd_data_a_q;
        rd_busy_a_d = rd_busy_a_q;
        if (bus.rd_en_a) begin
            rd_data_a_d = '0;
            rd_busy_a_d = 1'b0;
            if (idx_valid(int'(bus.rd_idx_a), N_REGS, ZERO_REG)) begin
                rd_data_a_d = regs_q[bus.rd_idx_a];
                rd_busy_a_d = look_busy_a;
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (bus.wr_idx == bus.rd_idx_a)) rd_data_a_d = bus.wr_data;
`endif
            end
        end

        rd_data_b_d = rd_data_b_q;
        rd_busy_b_d = rd_busy_b_q;
        if (bus.rd_en_b) begin
            rd_data_b_d = '0;
            rd_busy_b_d = 1'b0;
            if (idx_valid(int'(bus.rd_idx_b), N_REGS, ZERO_REG)) begin
                rd_data_b_d = regs_q[bus.rd_idx_b];
                rd_busy_b_d = look_busy_b;
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (bus.wr_idx == bus.rd_idx_b)) rd_data_b_d = bus.wr_data;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q      <= '{default: '0};
            rd_data_a_q <= '0;
            rd_busy_a_q <= 1'b0;
            rd_data_b_q <= '0;
            rd_busy_b_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            rd_data_a_q <= rd_data_a_d;
            rd_busy_a_q <= rd_busy_a_d;
            rd_data_b_q <= rd_data_b_d;
            rd_busy_b_q <= rd_busy_b_d;
        end
    end

    assign bus.rd_data_a = rd_data_a_q;
    assign bus.rd_busy_a = rd_busy_a_q;
    assign bus.rd_data_b = rd_data_b_q;
    assign bus.rd_busy_b = rd_busy_b_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: a default instance plus a ZERO_REG=1,
// N_REGS=6 instance for the hardwired-zero and out-of-range index cases.
module tb_regfile_2r1w;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       busy;
        string      tag;
    } exp_t;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    exp_t qa[$], qb[$], qza[$], qzb[$];
    logic sa, sb, sza, szb;

    regfile_2r1w_if #(.N_REGS(8), .REG_WIDTH(8)) bus ();
    regfile_2r1w_if #(.N_REGS(6), .REG_WIDTH(8)) zbus ();

    regfile_2r1w #(.N_REGS(8), .REG_WIDTH(8), .ZERO_REG(0)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    regfile_2r1w #(.N_REGS(6), .REG_WIDTH(8), .ZERO_REG(1)) dut_z (
        .clk  (clk),
        .reset(reset),
        .bus  (zbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic chk_read(input string port, input exp_t e, input logic [7:0] d, input logic b);
        chk({e.tag, "_", port, "_data"}, d, e.data);
        chk({e.tag, "_", port, "_busy"}, {7'b0, b}, {7'b0, e.busy});
    endtask

    // Which ports had rd_en sampled at the last edge
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sa <= 1'b0; sb <= 1'b0; sza <= 1'b0; szb <= 1'b0;
        end else begin
            sa  <= bus.rd_en_a;
            sb  <= bus.rd_en_b;
            sza <= zbus.rd_en_a;
            szb <= zbus.rd_en_b;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sa) begin
            if (qa.size() == 0) begin checks++; errors++; $display("FAIL unexpected_read_A"); end
            else begin e = qa.pop_front(); chk_read("A", e, bus.rd_data_a, bus.rd_busy_a); end
        end
        if (sb) begin
            if (qb.size() == 0) begin checks++; errors++; $display("FAIL unexpected_read_B"); end
            else begin e = qb.pop_front(); chk_read("B", e, bus.rd_data_b, bus.rd_busy_b); end
        end
        if (sza) begin
            if (qza.size() == 0) begin checks++; errors++; $display("FAIL unexpected_read_ZA"); end
            else begin e = qza.pop_front(); chk_read("ZA", e, zbus.rd_data_a, zbus.rd_busy_a); end
        end
        if (szb) begin
            if (qzb.size() == 0) begin checks++; errors++; $display("FAIL unexpected_read_ZB"); end
            else begin e = qzb.pop_front(); chk_read("ZB", e, zbus.rd_data_b, zbus.rd_busy_b); end
        end
    end

    task automatic idle();
        bus.wr_en = 1'b0;  bus.rd_en_a = 1'b0;  bus.rd_en_b = 1'b0;  bus.rsv_en = 1'b0;
        zbus.wr_en = 1'b0; zbus.rd_en_a = 1'b0; zbus.rd_en_b = 1'b0; zbus.rsv_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input int i, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_idx = 3'(i); bus.wr_data = d;
    endtask
    task automatic rsv(input int i);
        bus.rsv_en = 1'b1; bus.rsv_idx = 3'(i);
    endtask
    task automatic rda(input int i, input logic [7:0] d, input logic b, input string tag);
        bus.rd_en_a = 1'b1; bus.rd_idx_a = 3'(i);
        qa.push_back('{data: d, busy: b, tag: tag});
    endtask
    task automatic rdb(input int i, input logic [7:0] d, input logic b, input string tag);
        bus.rd_en_b = 1'b1; bus.rd_idx_b = 3'(i);
        qb.push_back('{data: d, busy: b, tag: tag});
    endtask
    task automatic zwr(input int i, input logic [7:0] d);
        zbus.wr_en = 1'b1; zbus.wr_idx = 3'(i); zbus.wr_data = d;
    endtask
    task automatic zrsv(input int i);
        zbus.rsv_en = 1'b1; zbus.rsv_idx = 3'(i);
    endtask
    task automatic zrda(input int i, input logic [7:0] d, input logic b, input string tag);
        zbus.rd_en_a = 1'b1; zbus.rd_idx_a = 3'(i);
        qza.push_back('{data: d, busy: b, tag: tag});
    endtask
    task automatic zrdb(input int i, input logic [7:0] d, input logic b, input string tag);
        zbus.rd_en_b = 1'b1; zbus.rd_idx_b = 3'(i);
        qzb.push_back('{data: d, busy: b, tag: tag});
    endtask

    initial begin
        idle();
        bus.wr_idx = '0;  bus.wr_data = '0;  bus.rd_idx_a = '0;  bus.rd_idx_b = '0;  bus.rsv_idx = '0;
        zbus.wr_idx = '0; zbus.wr_data = '0; zbus.rd_idx_a = '0; zbus.rd_idx_b = '0; zbus.rsv_idx = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #2;
        chk("por_rd_data_a", bus.rd_data_a, 8'h00);
        chk("por_rd_data_b", bus.rd_data_b, 8'h00);
        chk("por_rd_busy_a", {7'b0, bus.rd_busy_a}, 8'h00);
        @(negedge clk) reset = 1'b1;
        tick();

        // 1: load registers, mark r6 busy, then reset mid-run
        wr(1, 8'h55); tick();
        wr(3, 8'h99); rsv(6); tick();
        rda(1, 8'h55, 1'b0, "t1_pre"); rdb(6, 8'h00, 1'b1, "t1_pre"); tick();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("t1_rst_data_a", bus.rd_data_a, 8'h00);
        chk("t1_rst_data_b", bus.rd_data_b, 8'h00);
        chk("t1_rst_busy_a", {7'b0, bus.rd_busy_a}, 8'h00);
        chk("t1_rst_busy_b", {7'b0, bus.rd_busy_b}, 8'h00);
        rsv(6);
        #1 chk("t1_rst_stall", {7'b0, bus.rsv_stall}, 8'h00);
        idle();
        @(negedge clk) reset = 1'b1;
        rda(1, 8'h00, 1'b0, "t1_post"); rdb(6, 8'h00, 1'b0, "t1_post"); tick();
        rsv(6);
        #1 chk("t1_post_stall", {7'b0, bus.rsv_stall}, 8'h00);
        tick();

        // 2: write then dual read of the same index, outputs hold afterwards
        wr(3, 8'hA5); tick();
        tick();
        rda(3, 8'hA5, 1'b0, "t2"); rdb(3, 8'hA5, 1'b0, "t2"); tick();
        tick(); tick();
        chk("t2_hold_a", bus.rd_data_a, 8'hA5);
        chk("t2_hold_b", bus.rd_data_b, 8'hA5);

        // 3: read of an index written in the same cycle
        wr(5, 8'h11); tick();
        wr(5, 8'h3C); rda(5, BYP ? 8'h3C : 8'h11, 1'b0, "t3_same"); tick();
        rda(5, 8'h3C, 1'b0, "t3_after"); tick();

        // 4: reserve, duplicate reserve stalls, write releases
        rsv(2);
        #1 chk("t4_first_stall", {7'b0, bus.rsv_stall}, 8'h00);
        tick();
        rsv(2);
        #1 chk("t4_second_stall", {7'b0, bus.rsv_stall}, 8'h01);
        tick();
        rda(2, 8'h00, 1'b1, "t4_busy"); tick();
        wr(2, 8'h7E); tick();
        rda(2, 8'h7E, 1'b0, "t4_rel"); tick();
        rsv(2);
        #1 chk("t4_rersv_stall", {7'b0, bus.rsv_stall}, 8'h00);
        tick();
        wr(2, 8'h7F); rdb(2, BYP ? 8'h7F : 8'h7E, 1'b0, "t4_wr_rd"); tick();

        // 5: write and reserve of the same index in one cycle
        rsv(4); tick();
        wr(4, 8'h44); rsv(4);
        #1 chk("t5_busy_stall", {7'b0, bus.rsv_stall}, 8'h01);
        tick();
        rda(4, 8'h44, 1'b1, "t5_busy"); tick();
        wr(4, 8'h45); tick();
        wr(4, 8'h46); rsv(4); rdb(4, BYP ? 8'h46 : 8'h45, 1'b0, "t5_same");
        #1 chk("t5_idle_stall", {7'b0, bus.rsv_stall}, 8'h00);
        tick();
        rda(4, 8'h46, 1'b1, "t5_idle"); tick();

        // 6: hardwired r0 and out-of-range index on the ZERO_REG, N_REGS=6 instance
        zwr(0, 8'hFF); zrsv(0); zrdb(0, 8'h00, 1'b0, "t6_r0_same");
        #1 chk("t6_r0_stall", {7'b0, zbus.rsv_stall}, 8'h00);
        tick();
        zrsv(0); zrda(0, 8'h00, 1'b0, "t6_r0");
        #1 chk("t6_r0_stall2", {7'b0, zbus.rsv_stall}, 8'h00);
        tick();
        zwr(6, 8'h77); zrsv(6);
        #1 chk("t6_oob_stall", {7'b0, zbus.rsv_stall}, 8'h00);
        tick();
        zrsv(6); zrda(6, 8'h00, 1'b0, "t6_oob");
        #1 chk("t6_oob_stall2", {7'b0, zbus.rsv_stall}, 8'h00);
        tick();
        zwr(1, 8'h12); zrsv(1); tick();
        zrsv(1); zrdb(1, 8'h12, 1'b1, "t6_r1");
        #1 chk("t6_r1_stall", {7'b0, zbus.rsv_stall}, 8'h01);
        tick();

        tick(); tick(); tick();
        chk("drain_qa",  8'(qa.size()),  8'h00);
        chk("drain_qb",  8'(qb.size()),  8'h00);
        chk("drain_qza", 8'(qza.size()), 8'h00);
        chk("drain_qzb", 8'(qzb.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
